// File: rtl/multilane_inst_fifo.sv
// Multi-lane in-order instruction queue: up to LANES pushes and LANES pops per cycle,
// with partial pops on underflow, flush, and a sticky error flag for out-of-range counts.
module multilane_inst_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int LANES  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int NUM_W = $clog2(LANES + 1)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic                      wr_valid,
    input  logic [NUM_W-1:0]          wr_num,
    input  logic [LANES*DATA_W-1:0]   wr_data,
    output logic                      wr_ready,
    input  logic                      rd_en,
    input  logic [NUM_W-1:0]          rd_num,
    output logic [LANES*DATA_W-1:0]   rd_data,
    output logic [LANES-1:0]          rd_lane_valid,
    output logic [NUM_W-1:0]          rd_popped,
    output logic [PTR_W:0]            count,
    output logic                      empty,
    output logic                      full,
    output logic                      err
);

    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              wr_num_ok;
    logic              rd_num_ok;
    logic [CNT_W-1:0]  free_slots;
    logic              push_acc;
    logic [NUM_W-1:0]  pushed;

    assign wr_num_ok  = (wr_num <= NUM_W'(LANES));
    assign rd_num_ok  = (rd_num <= NUM_W'(LANES));
    // Free space is judged on the pre-pop occupancy, so a same-cycle pop never helps a push.
    assign free_slots = CNT_W'(DEPTH) - count;
    assign wr_ready   = wr_num_ok && (free_slots >= CNT_W'(wr_num));
    assign push_acc   = wr_valid && wr_ready && !flush;
    assign pushed     = push_acc ? wr_num : '0;

    always_comb begin
        rd_popped = '0;
        if (rd_en && !flush && rd_num_ok) begin
            if (CNT_W'(rd_num) <= count) rd_popped = rd_num;
            else                         rd_popped = NUM_W'(count);
        end
    end

    always_comb begin
        rd_data       = '0;
        rd_lane_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) < count) begin
                rd_lane_valid[i]             = 1'b1;
                rd_data[i*DATA_W +: DATA_W]  = mem[rptr + PTR_W'(i)];
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Storage is deliberately left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (rstn && push_acc && (NUM_W'(i) < wr_num))
                mem[wptr + PTR_W'(i)] <= wr_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PTR_W'(pushed);
            rptr  <= rptr + PTR_W'(rd_popped);
            count <= count - CNT_W'(rd_popped) + CNT_W'(pushed);
        end
    end

    // Sticky error survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn)
            err <= 1'b0;
        else if ((wr_valid && !wr_num_ok) || (rd_en && !rd_num_ok))
            err <= 1'b1;
    end

endmodule

// File: tb/tb_multilane_inst_fifo.sv
// Bench for multilane_inst_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_multilane_inst_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int LANES  = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic         flush;
    logic         wr_valid;
    logic [3:0]   wr_num;
    logic [255:0] wr_data;
    logic         wr_ready;
    logic         rd_en;
    logic [3:0]   rd_num;
    logic [255:0] rd_data;
    logic [7:0]   rd_lane_valid;
    logic [3:0]   rd_popped;
    logic [5:0]   count;
    logic         empty;
    logic         full;
    logic         err;

    multilane_inst_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .wr_valid(wr_valid), .wr_num(wr_num), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_num(rd_num), .rd_data(rd_data), .rd_lane_valid(rd_lane_valid),
        .rd_popped(rd_popped), .count(count), .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: an ordered queue of entries plus a sticky error bit.
    logic [31:0] q[$];
    bit          m_err;
    bit          checking = 0;

    function automatic int exp_popped();
        int cnt = q.size();
        if (rd_en && !flush && rd_num <= 4'(LANES))
            return (int'(rd_num) < cnt) ? int'(rd_num) : cnt;
        return 0;
    endfunction

    function automatic bit exp_ready();
        return (wr_num <= 4'(LANES)) && (DEPTH - q.size() >= int'(wr_num));
    endfunction

    always @(posedge clk) begin
        int pop_n;
        bit acc;
        if (!rstn) begin
            q.delete();
            m_err    = 0;
            checking = 1;
        end else begin
            if ((wr_valid && wr_num > 4'(LANES)) || (rd_en && rd_num > 4'(LANES))) m_err = 1;
            if (flush) begin
                q.delete();
            end else begin
                pop_n = exp_popped();
                acc   = wr_valid && exp_ready();
                for (int i = 0; i < pop_n; i++) void'(q.pop_front());
                if (acc)
                    for (int i = 0; i < int'(wr_num); i++) q.push_back(wr_data[i*32 +: 32]);
            end
        end
    end

    always @(negedge clk) begin
        logic [255:0] e_data;
        logic [7:0]   e_valid;
        int           cnt;
        if (checking) begin
            cnt     = q.size();
            e_data  = '0;
            e_valid = '0;
            for (int i = 0; i < LANES; i++) begin
                if (i < cnt) begin
                    e_valid[i]         = 1'b1;
                    e_data[i*32 +: 32] = q[i];
                end
            end
            chk("m_count", count, cnt);
            chk("m_empty", empty, cnt == 0);
            chk("m_full", full, cnt == DEPTH);
            chk("m_err", err, m_err);
            chk("m_wr_ready", wr_ready, exp_ready());
            chk("m_rd_popped", rd_popped, exp_popped());
            chk("m_lane_valid", rd_lane_valid, e_valid);
            chk("m_rd_data", rd_data, e_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input logic [31:0] base);
        wr_valid = 1'b1;
        wr_num   = 4'(n);
        for (int i = 0; i < LANES; i++) wr_data[i*32 +: 32] = base + 32'(i);
    endtask

    task automatic pop(input int n);
        rd_en  = 1'b1;
        rd_num = 4'(n);
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        wr_num   = '0;
        rd_en    = 1'b0;
        rd_num   = '0;
        flush    = 1'b0;
    endtask

    initial begin
        rstn    = 1'b0;
        wr_data = '0;
        idle();
        cyc();
        cyc();
        rstn = 1'b1;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_lane_valid", rd_lane_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_err", err, 0);

        // Push 8, pop 3
        push(8, 32'hA0);
        cyc();
        idle();
        pop(3);
        #2;
        chk("t1_popped", rd_popped, 3);
        cyc();
        idle();
        #2;
        chk("t1_count", count, 5);
        chk("t1_valid", rd_lane_valid, 8'h1F);
        chk("t1_lane0", rd_data[31:0], 32'hA3);
        chk("t1_lane4", rd_data[4*32 +: 32], 32'hA7);
        chk("t1_lane5", rd_data[5*32 +: 32], 0);

        // Fill to full, then reject a push
        flush = 1'b1;
        cyc();
        idle();
        for (int k = 0; k < 4; k++) begin
            push(8, 32'hC0 + 32'(k * 8));
            cyc();
        end
        push(1, 32'hEE);
        #2;
        chk("t2_count", count, 32);
        chk("t2_full", full, 1);
        chk("t2_ready", wr_ready, 0);
        cyc();
        idle();
        #2;
        chk("t2_count_hold", count, 32);

        // Wrap across the DEPTH-1 -> 0 boundary
        flush = 1'b1;
        cyc();
        idle();
        for (int k = 0; k < 4; k++) begin
            push(k == 3 ? 6 : 8, 32'h100 + 32'(k * 8));
            cyc();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            pop(k == 3 ? 6 : 8);
            cyc();
        end
        idle();
        push(8, 32'hB0);
        cyc();
        idle();
        pop(8);
        #2;
        for (int i = 0; i < LANES; i++)
            chk("t3_wrap_lane", rd_data[i*32 +: 32], 32'hB0 + 32'(i));
        chk("t3_popped", rd_popped, 8);
        cyc();
        idle();
        #2;
        chk("t3_empty", empty, 1);

        // Underflow pop is partial, not an error
        push(2, 32'h50);
        cyc();
        idle();
        pop(8);
        #2;
        chk("t4_popped", rd_popped, 2);
        cyc();
        idle();
        #2;
        chk("t4_count", count, 0);
        chk("t4_empty", empty, 1);
        chk("t4_err", err, 0);

        // Push blocked by pre-pop occupancy while pop proceeds
        for (int k = 0; k < 4; k++) begin
            push(k == 3 ? 4 : 8, 32'h200 + 32'(k * 8));
            cyc();
        end
        idle();
        push(6, 32'h300);
        pop(8);
        #2;
        chk("t5_ready", wr_ready, 0);
        chk("t5_popped", rd_popped, 8);
        cyc();
        idle();
        #2;
        chk("t5_count", count, 20);

        // Flush beats push; out-of-range count sets sticky err
        flush = 1'b1;
        cyc();
        idle();
        push(8, 32'h400);
        cyc();
        push(2, 32'h408);
        cyc();
        idle();
        #2;
        chk("t6_count10", count, 10);
        flush = 1'b1;
        push(4, 32'h410);
        cyc();
        idle();
        #2;
        chk("t6_flush_count", count, 0);
        push(9, 32'h500);
        #2;
        chk("t6_ready9", wr_ready, 0);
        cyc();
        idle();
        #2;
        chk("t6_err_set", err, 1);
        flush = 1'b1;
        cyc();
        cyc();
        idle();
        #2;
        chk("t6_err_sticky", err, 1);
        push(3, 32'hD0);
        cyc();
        idle();
        pop(9);
        #2;
        chk("t6_pop9", rd_popped, 0);
        cyc();
        idle();
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        #2;
        chk("t6_err_clr", err, 0);
        chk("t6_rst_count", count, 0);
        push(3, 32'hE0);
        cyc();
        idle();
        pop(3);
        #2;
        chk("t6_post_rst_lane0", rd_data[31:0], 32'hE0);
        chk("t6_post_rst_lane2", rd_data[2*32 +: 32], 32'hE2);
        cyc();
        idle();
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
